door_motion_supervisor: RTL and testbench
=========================================

Name: door_motion_supervisor

Overview:
- Sits between the user inputs and door limit sensors on one side, and the garage-door motor controller (A_G_D_C-style FSM with Activate/UP_Max/DN_Max in, UP_M/DN_M out) on the other.
- Debounces and merges wall-button and remote requests, and issues Activate pulses. Can override the limit lines so the controller stops or reverses.
- Adds auto-close, obstruction reversal, a motion watchdog and a sticky fault.

Parameters:
- DEBOUNCE, 4, stable cycles a button must hold before its level is accepted
- MOVE_TIMEOUT, 1000, max cycles in motion before forced stop and fault
- AUTO_CLOSE, 500, cycles fully open and idle before an automatic close request
- CNT_W, 16, width of the motion/auto-close timer; must hold max(MOVE_TIMEOUT, AUTO_CLOSE)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- Wall_Btn  in  1  raw wall button, CLK-synchronous
- Remote_Btn  in  1  raw remote-receiver button, CLK-synchronous
- Obstruct  in  1  photo-beam blocked
- Auto_En  in  1  auto-close enable
- UP_Max_i  in  1  physical top-limit sensor
- DN_Max_i  in  1  physical bottom-limit sensor
- UP_M  in  1  controller motor-up output
- DN_M  in  1  controller motor-down output
- Activate  out  1  activate request to controller
- UP_Max_o  out  1  top limit to controller (sensor or forced)
- DN_Max_o  out  1  bottom limit to controller (sensor or forced)
- Busy  out  1  supervisor not in IDLE
- Fault  out  1  sticky fault flag

Behaviour:
- Reset (async, RST=0): state IDLE. Activate=0, Busy=0, Fault=0, force flags clear (UP_Max_o=UP_Max_i, DN_Max_o=DN_Max_i), timers 0, obstructed latch 0.
- Outputs:
  - Activate, Busy, Fault and force flags are registered.
  - Limit outputs are combinational: force flag ? forced value : sensor value.
- Debounce: per button, the counter restarts on level change; the new level is accepted after DEBOUNCE stable cycles. A request is the rising edge of the debounced level. Both buttons in the same cycle count as one request. Requests outside IDLE are discarded.
- IDLE, on request or auto-close expiry:
  - Exactly one sensor high: go to START.
  - Neither sensor high (mid-travel): go to START with recovery, forcing UP_Max_o=1, DN_Max_o=0 so the controller closes.
  - Both sensors high: go to FAULT.
  - UP_Max_i=1 and Obstruct=1: request ignored; stay IDLE.
- A user request clears the obstructed latch.
- Auto-close: counts only in IDLE with UP_Max_i=1, Auto_En=1, Obstruct=0 and obstructed latch=0; otherwise held at 0. The request fires when the count reaches AUTO_CLOSE-1.
- START: Activate=1 for exactly one cycle, with recovery force if selected; then go to WAIT_MOVE.
- WAIT_MOVE: UP_M|DN_M must assert within 2 cycles.
  - If it does: go to MOVING with the timer cleared.
  - If not: go to FAULT.
- MOVING: timer increments each cycle.
  - UP_M=DN_M=0: go to IDLE.
  - Timer = MOVE_TIMEOUT-1: go to STOP_FLT.
  - Obstruct=1 while DN_M=1: go to STOP_REV and set the obstructed latch.
  - Obstruct while UP_M=1: ignored.
  - Priority: timeout > obstruct > normal end.
- STOP_FLT: force UP_Max_o=DN_Max_o=1 for one cycle (controller stops from either direction); then go to FAULT.
- STOP_REV: force both limits =1 for one cycle; then go to REVERSE.
- REVERSE: force DN_Max_o=1, UP_Max_o=0 and Activate=1 for one cycle; then go to WAIT_MOVE.
- FAULT: Fault=1, Activate=0, no forcing, all requests ignored; exit only by reset.
- Busy=1 in every state except IDLE.
- Reset mid-motion: outputs return to reset values immediately; the controller is reset by the same RST.

Decomposition:
- Shared package door_pkg:
  - State encoding localparams: IDLE, START, WAIT_MOVE, MOVING, STOP_FLT, STOP_REV, REVERSE, FAULT (3-bit).
  - Default DEBOUNCE / MOVE_TIMEOUT / AUTO_CLOSE constants.
- One sub-module: btn_debounce (param DEBOUNCE; in CLK, RST, raw; out level, rise_pulse), instantiated twice.

Test Plan:
- Closed (DN_Max_i=1), Wall_Btn high 6 cycles -> one Activate pulse 4+1 cycles after press; model gives UP_M=1; on UP_Max_i, UP_M drops -> Busy=0.
- Open, Auto_En=1, AUTO_CLOSE=8, idle -> Activate at cycle 8; DN_M=1; Obstruct mid-close -> one cycle UP_Max_o=DN_Max_o=1, next cycle DN_Max_o=1 with Activate -> UP_M=1; afterwards no auto-close until a button press.
- Wall_Btn and Remote_Btn pressed same cycle -> exactly one Activate pulse; 2-cycle glitch on Wall_Btn -> no Activate.
- MOVE_TIMEOUT=16, limit never reached -> at cycle 16 both limits forced 1 for one cycle, motor stops, Fault=1; later presses -> no Activate.
- Neither sensor high, press -> Activate with UP_Max_o=1 forced -> DN_M=1; both sensors high, press -> Fault=1, no Activate.
- RST low during MOVING -> Activate=0, Busy=0, Fault=0, limits follow sensors immediately.

Source files
------------

// File: rtl/door_pkg.sv
// Shared definitions for the door motion supervisor.
//   state_t          : supervisor FSM states (3-bit)
//   *_DEF constants  : default timing parameters
package door_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_MOVE = 3'd2,
        MOVING    = 3'd3,
        STOP_FLT  = 3'd4,
        STOP_REV  = 3'd5,
        REVERSE   = 3'd6,
        FAULT     = 3'd7
    } state_t;

    localparam int DEBOUNCE_DEF     = 4;
    localparam int MOVE_TIMEOUT_DEF = 1000;
    localparam int AUTO_CLOSE_DEF   = 500;
    localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer.
//   CLK, RST    : clock, asynchronous active-low reset
//   raw         : raw button level, CLK-synchronous
//   level       : debounced level (accepted after DEBOUNCE stable cycles)
//   rise_pulse  : one-cycle pulse when the debounced level goes high
module btn_debounce
    import door_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt;

    // The counter only runs while raw differs from the accepted level, so any
    // return to the old level restarts the stability window.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            cnt        <= '0;
        end else begin
            rise_pulse <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level      <= raw;
                rise_pulse <= raw;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/door_motion_supervisor.sv
// Supervisor between user inputs / limit sensors and the garage-door motor
// controller. Debounces and merges button requests, issues Activate pulses,
// overrides the limit lines to stop or reverse the controller, and adds
// auto-close, obstruction reversal, a motion watchdog and a sticky fault.
//   CLK, RST             : clock, asynchronous active-low reset
//   Wall_Btn, Remote_Btn : raw buttons
//   Obstruct             : photo-beam blocked
//   Auto_En              : auto-close enable
//   UP_Max_i, DN_Max_i   : physical limit sensors
//   UP_M, DN_M           : controller motor outputs
//   Activate             : activate request to controller (registered)
//   UP_Max_o, DN_Max_o   : limits to controller (sensor or forced value)
//   Busy                 : supervisor not idle (registered)
//   Fault                : sticky fault (registered)
module door_motion_supervisor
    import door_pkg::*;
#(
    parameter int DEBOUNCE     = DEBOUNCE_DEF,
    parameter int MOVE_TIMEOUT = MOVE_TIMEOUT_DEF,
    parameter int AUTO_CLOSE   = AUTO_CLOSE_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic Wall_Btn,
    input  logic Remote_Btn,
    input  logic Obstruct,
    input  logic Auto_En,
    input  logic UP_Max_i,
    input  logic DN_Max_i,
    input  logic UP_M,
    input  logic DN_M,
    output logic Activate,
    output logic UP_Max_o,
    output logic DN_Max_o,
    output logic Busy,
    output logic Fault
);

    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] AC_LAST   = CNT_W'(AUTO_CLOSE - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             obstructed;
    logic             force_up, force_dn;
    logic             up_val, dn_val;

    logic wall_level, wall_rise, remote_level, remote_rise;
    logic user_req, ac_run, ac_fire, req;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_wall (
        .CLK(CLK), .RST(RST), .raw(Wall_Btn),
        .level(wall_level), .rise_pulse(wall_rise)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_remote (
        .CLK(CLK), .RST(RST), .raw(Remote_Btn),
        .level(remote_level), .rise_pulse(remote_rise)
    );

    // A press while the other button is already held down belongs to the
    // same user action; simultaneous rises collapse into one request.
    assign user_req = (wall_rise   & ~(remote_level & ~remote_rise))
                    | (remote_rise & ~(wall_level   & ~wall_rise));

    assign ac_run  = (state == IDLE) && UP_Max_i && Auto_En && !Obstruct && !obstructed;
    assign ac_fire = ac_run && (timer == AC_LAST);
    assign req     = user_req || ac_fire;

    assign UP_Max_o = force_up ? up_val : UP_Max_i;
    assign DN_Max_o = force_dn ? dn_val : DN_Max_i;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            timer      <= '0;
            obstructed <= 1'b0;
            force_up   <= 1'b0;
            force_dn   <= 1'b0;
            up_val     <= 1'b0;
            dn_val     <= 1'b0;
            Activate   <= 1'b0;
            Busy       <= 1'b0;
            Fault      <= 1'b0;
        end else begin
            Activate <= 1'b0;
            case (state)
                IDLE: begin
                    if (user_req) obstructed <= 1'b0;
                    if (req && !(UP_Max_i && Obstruct)) begin
                        timer <= '0;
                        Busy  <= 1'b1;
                        if (UP_Max_i && DN_Max_i) begin
                            state <= FAULT;
                            Fault <= 1'b1;
                        end else begin
                            state    <= START;
                            Activate <= 1'b1;
                            // Mid-travel: present "open" so the controller closes.
                            if (!UP_Max_i && !DN_Max_i) begin
                                force_up <= 1'b1;
                                up_val   <= 1'b1;
                                force_dn <= 1'b1;
                                dn_val   <= 1'b0;
                            end
                        end
                    end else if (ac_run) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                START: begin
                    state    <= WAIT_MOVE;
                    force_up <= 1'b0;
                    force_dn <= 1'b0;
                    timer    <= '0;
                end
                WAIT_MOVE: begin
                    if (UP_M || DN_M) begin
                        state <= MOVING;
                        timer <= '0;
                    end else if (timer == WAIT_LAST) begin
                        state <= FAULT;
                        Fault <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                MOVING: begin
                    if (timer == MOVE_LAST) begin
                        state    <= STOP_FLT;
                        force_up <= 1'b1;
                        up_val   <= 1'b1;
                        force_dn <= 1'b1;
                        dn_val   <= 1'b1;
                    end else if (Obstruct && DN_M) begin
                        state      <= STOP_REV;
                        obstructed <= 1'b1;
                        force_up   <= 1'b1;
                        up_val     <= 1'b1;
                        force_dn   <= 1'b1;
                        dn_val     <= 1'b1;
                    end else if (!UP_M && !DN_M) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP_FLT: begin
                    state    <= FAULT;
                    Fault    <= 1'b1;
                    force_up <= 1'b0;
                    force_dn <= 1'b0;
                end
                STOP_REV: begin
                    // Controller is now stopped at a "closed" view; reopen it.
                    state    <= REVERSE;
                    up_val   <= 1'b0;
                    dn_val   <= 1'b1;
                    Activate <= 1'b1;
                end
                REVERSE: begin
                    state    <= WAIT_MOVE;
                    force_up <= 1'b0;
                    force_dn <= 1'b0;
                    timer    <= '0;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_door_motion_supervisor.sv
// Self-checking bench for door_motion_supervisor with a behavioural motor
// controller. Activate pulses are checked by a scoreboard monitor against
// expected (cycle, UP_Max_o, DN_Max_o) records pushed by the stimulus.
module tb_door_motion_supervisor;

    logic CLK = 1'b0;
    logic RST;
    logic Wall_Btn, Remote_Btn, Obstruct, Auto_En;
    logic up_s, dn_s;
    logic up_m, dn_m;
    logic Activate, UP_Max_o, DN_Max_o, Busy, Fault;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int act_seen = 0;

    typedef struct {
        int   cyc;
        logic up;
        logic dn;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    door_motion_supervisor #(
        .DEBOUNCE(4), .MOVE_TIMEOUT(16), .AUTO_CLOSE(8), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .Wall_Btn(Wall_Btn), .Remote_Btn(Remote_Btn),
        .Obstruct(Obstruct), .Auto_En(Auto_En),
        .UP_Max_i(up_s), .DN_Max_i(dn_s),
        .UP_M(up_m), .DN_M(dn_m),
        .Activate(Activate), .UP_Max_o(UP_Max_o), .DN_Max_o(DN_Max_o),
        .Busy(Busy), .Fault(Fault)
    );

    // Controller model: on Activate while stopped, close if it sees the top
    // limit, otherwise open; stop on reaching the limit of travel.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            up_m <= 1'b0;
            dn_m <= 1'b0;
        end else if (!up_m && !dn_m) begin
            if (Activate) begin
                if (UP_Max_o) dn_m <= 1'b1;
                else          up_m <= 1'b1;
            end
        end else if (up_m && UP_Max_o) begin
            up_m <= 1'b0;
        end else if (dn_m && DN_Max_o) begin
            dn_m <= 1'b0;
        end
    end

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (RST === 1'b1 && Activate === 1'b1) begin
            exp_t e;
            act_seen++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_activate cyc=%0d got Activate=1 want none", cyc);
            end else begin
                e = sb.pop_front();
                if ((e.cyc >= 0 && e.cyc != cyc) || UP_Max_o !== e.up || DN_Max_o !== e.dn) begin
                    n_err++;
                    $display("FAIL activate_pulse got cyc=%0d up=%b dn=%b want cyc=%0d up=%b dn=%b",
                             cyc, UP_Max_o, DN_Max_o, e.cyc, e.up, e.dn);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cyc=%0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_act(input int at, input logic up, input logic dn);
        exp_t e;
        e.cyc = at;
        e.up  = up;
        e.dn  = dn;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        RST = 1'b0; Wall_Btn = 0; Remote_Btn = 0; Obstruct = 0; Auto_En = 0;
        up_s = 0; dn_s = 1;
        #3;
        check("rst_activate", Activate, 0);
        check("rst_busy", Busy, 0);
        check("rst_fault", Fault, 0);
        check("rst_up_o", UP_Max_o, 0);
        check("rst_dn_o", DN_Max_o, 1);
        tick(2);
        RST = 1'b1;
        tick(2);

        // Test 1: closed, wall press -> open
        Wall_Btn = 1; expect_act(cyc + 5, 0, 1);
        tick(6); Wall_Btn = 0;
        check("t1_motor_up", up_m, 1);
        check("t1_busy", Busy, 1);
        tick(2); dn_s = 0;
        tick(3); up_s = 1;
        tick(2);
        check("t1_idle_busy", Busy, 0);
        check("t1_motor_stopped", up_m, 0);

        // Test 2: auto-close, obstruction reversal, latch
        Auto_En = 1; expect_act(cyc + 8, 1, 0);
        tick(9);
        check("t2_motor_dn", dn_m, 1);
        up_s = 0;
        tick(2);
        Obstruct = 1; expect_act(cyc + 2, 0, 1);
        tick(1);
        check("t2_stoprev_up_o", UP_Max_o, 1);
        check("t2_stoprev_dn_o", DN_Max_o, 1);
        tick(1);
        check("t2_reverse_up_o", UP_Max_o, 0);
        check("t2_reverse_dn_o", DN_Max_o, 1);
        check("t2_motor_dn_stopped", dn_m, 0);
        tick(1);
        check("t2_motor_up", up_m, 1);
        tick(3);
        check("t2_obst_ignored_up", up_m, 1);
        Obstruct = 0; up_s = 1;
        tick(3);
        check("t2_idle", Busy, 0);
        a = act_seen;
        tick(20);
        check("t2_no_autoclose", act_seen, a);
        Wall_Btn = 1; expect_act(cyc + 5, 1, 0);
        tick(6); Wall_Btn = 0;
        check("t2_press_closes", dn_m, 1);
        up_s = 0;
        tick(3); dn_s = 1;
        tick(3);
        check("t2_closed_idle", Busy, 0);
        Auto_En = 0;

        // Test 3: simultaneous buttons, glitch
        Wall_Btn = 1; Remote_Btn = 1; expect_act(cyc + 5, 0, 1);
        tick(6); Wall_Btn = 0; Remote_Btn = 0;
        check("t3_motor_up", up_m, 1);
        dn_s = 0;
        tick(2); up_s = 1;
        tick(3);
        check("t3_idle", Busy, 0);
        a = act_seen;
        Wall_Btn = 1; tick(2); Wall_Btn = 0;
        tick(10);
        check("t3_glitch_no_act", act_seen, a);

        // Test 4: motion timeout
        Wall_Btn = 1; expect_act(cyc + 5, 1, 0);
        tick(5); Wall_Btn = 0;
        tick(1);
        check("t4_motor_dn", dn_m, 1);
        up_s = 0;
        tick(17);
        check("t4_stopflt_up_o", UP_Max_o, 1);
        check("t4_stopflt_dn_o", DN_Max_o, 1);
        check("t4_fault_pending", Fault, 0);
        tick(1);
        check("t4_fault", Fault, 1);
        check("t4_motor_stopped", dn_m, 0);
        check("t4_unforced_dn_o", DN_Max_o, 0);
        a = act_seen;
        Wall_Btn = 1; tick(6); Wall_Btn = 0;
        tick(4);
        check("t4_fault_no_act", act_seen, a);
        check("t4_fault_sticky", Fault, 1);
        check("t4_fault_busy", Busy, 1);

        // Test 5: mid-travel recovery, both sensors high
        RST = 0; dn_s = 0; #1;
        check("t5_rst_fault", Fault, 0);
        check("t5_rst_busy", Busy, 0);
        tick(2); RST = 1; tick(2);
        Wall_Btn = 1; expect_act(cyc + 5, 1, 0);
        tick(6); Wall_Btn = 0;
        check("t5_recovery_dn", dn_m, 1);
        check("t5_force_released", UP_Max_o, 0);
        tick(2); dn_s = 1;
        tick(3);
        check("t5_idle", Busy, 0);
        up_s = 1;
        a = act_seen;
        Wall_Btn = 1;
        tick(5);
        check("t5_both_fault", Fault, 1);
        tick(1); Wall_Btn = 0;
        tick(5);
        check("t5_both_no_act", act_seen, a);

        // Test 6: reset during motion
        RST = 0; tick(2);
        up_s = 0; dn_s = 1; RST = 1; tick(2);
        Wall_Btn = 1; expect_act(cyc + 5, 0, 1);
        tick(6); Wall_Btn = 0;
        tick(2); dn_s = 0; tick(1);
        check("t6_busy_moving", Busy, 1);
        RST = 0; #1;
        check("t6_rst_activate", Activate, 0);
        check("t6_rst_busy", Busy, 0);
        check("t6_rst_fault", Fault, 0);
        check("t6_rst_dn_o", DN_Max_o, 0);
        up_s = 1; #1;
        check("t6_rst_up_follow", UP_Max_o, 1);
        tick(1); RST = 1; tick(2);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
